// File: rtl/issue_scoreboard.sv
// issue_scoreboard: RV32I decode-stage issue controller with a 32-entry busy scoreboard.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback clear hazards.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instIn,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            instOut,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  output logic                   illegal_op,
  output logic [31:0]            busy_map,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
                         OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;
  logic [IW-1:0] inflight, dec;
  logic [4:0] out_rd;
  logic out_wr, u1, u2, wr, wr_nz, known, hazard, limit, acc, wb_clr, fl_clr, fl_dup;
  logic [31:0] bz, set_m, clr_m;
`ifdef SCOREBOARD_WB_BYPASS_EN
  assign bz = busy_map & ~(wb_valid ? 32'd1 << wb_rd : 32'd0);
`else
  assign bz = busy_map;
`endif
  always_comb begin
    u1 = opcode inside {OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP};
    u2 = opcode inside {OP_BR, OP_ST, OP_OP};
    wr = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_OP};
    known = wr || u1 || opcode inside {OP_FENCE, OP_SYS};
    wr_nz = wr && rd != 5'd0;
    hazard = (u1 ? bz[rs1] : 1'b0) | (u2 ? bz[rs2] : 1'b0) | (wr_nz ? bz[rd] : 1'b0);
    limit = wr_nz && inflight == IW'(MAX_INFLIGHT);
    in_ready = (!out_valid || out_ready) && !hazard && !limit && !flush;
    acc = in_valid && in_ready;
    wb_clr = wb_valid && busy_map[wb_rd];
    fl_clr = flush && out_valid && out_wr && busy_map[out_rd];
    fl_dup = wb_clr && fl_clr && wb_rd == out_rd;
    set_m = acc && wr_nz ? 32'd1 << rd : 32'd0;
    clr_m = (wb_clr ? 32'd1 << wb_rd : 32'd0) | (fl_clr ? 32'd1 << out_rd : 32'd0);
    dec = IW'(wb_clr) + IW'(fl_clr && !fl_dup);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_map <= '0;
      out_valid <= 1'b0;
      instOut <= '0;
      illegal_op <= 1'b0;
      stall_cnt <= '0;
      inflight <= '0;
      out_rd <= '0;
      out_wr <= 1'b0;
    end else begin
      busy_map <= ((busy_map & ~clr_m) | set_m) & ~32'd1;
      inflight <= inflight + IW'(acc && wr_nz) - dec;
      out_valid <= acc ? 1'b1 : (flush || out_ready) ? 1'b0 : out_valid;
      illegal_op <= acc && !known;
      if (acc) begin
        instOut <= instIn;
        out_rd <= rd;
        out_wr <= wr_nz;
      end
      if (in_valid && !in_ready && (hazard || limit) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed stimulus pushes expected issued words into a queue;
// a monitor pops and compares whenever execute consumes an output.
module tb_issue_scoreboard;
  typedef struct { logic [31:0] w; logic ill; } exp_t;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, wb_valid = 0, flush = 0;
  logic in_ready, out_valid, illegal_op;
  logic [31:0] instIn = 0, instOut, busy_map;
  logic [6:0] opcode = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0, wb_rd = 0;
  logic [15:0] stall_cnt;
  int tests = 0, fails = 0, exp_stall = 0, n;
  logic pushed;
  exp_t q[$];

  issue_scoreboard dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instIn(instIn), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
    .out_ready(out_ready), .instOut(instOut), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .illegal_op(illegal_op), .busy_map(busy_map), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] w);
    in_valid = 1; instIn = w; opcode = w[6:0]; rd = w[11:7]; rs1 = w[19:15]; rs2 = w[24:20];
  endtask

  task automatic issue(input logic [31:0] w, input logic ill, output int waited);
    exp_t e;
    waited = 0;
    drive(w);
    @(negedge clk);
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      fails++; tests++;
      $display("FAIL issue timeout: in_ready %b for %h, required 1", in_ready, w);
    end else begin
      e.w = w; e.ill = ill;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1; wb_rd = r;
    @(posedge clk); #1;
    wb_valid = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (q.size() == 0) chk("unexpected output", instOut, 32'hxxxxxxxx);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("instOut", instOut, e.w);
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
      end
    end
  end

  initial begin
    #1;
    chk("rst busy", busy_map, 0);
    chk("rst out_valid", {31'd0, out_valid}, 0);
    chk("rst stall", {16'd0, stall_cnt}, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    // RAW on x5
    issue(32'h00500293, 0, n);
    chk("addi x5 wait", n, 0);
    drive(32'h00528333);
    @(negedge clk);
    chk("raw ready", {31'd0, in_ready}, 0);
    chk("raw busy", busy_map, 32'h20);
    @(posedge clk); #1;
    chk("raw stall", {16'd0, stall_cnt}, 1);
    wb_valid = 1; wb_rd = 5;
    @(negedge clk);
    chk("wb cycle ready", {31'd0, in_ready}, {31'd0, BYP});
    pushed = in_ready;
    if (pushed) q.push_back('{32'h00528333, 1'b0});
    @(posedge clk); #1;
    wb_valid = 0;
    exp_stall = BYP ? 1 : 2;
    if (!pushed) begin
      @(negedge clk);
      chk("after wb ready", {31'd0, in_ready}, 1);
      q.push_back('{32'h00528333, 1'b0});
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("add busy", busy_map, 32'h40);
    @(posedge clk); #1;
    wb(6);
    @(negedge clk);
    chk("wb6 busy", busy_map, 0);
    // x0 rules
    @(posedge clk); #1;
    issue(32'h00100013, 0, n);
    chk("addi x0 wait", n, 0);
    @(negedge clk);
    chk("addi x0 busy", busy_map, 0);
    @(posedge clk); #1;
    issue(32'h000000b3, 0, n);
    chk("add x1 wait", n, 0);
    @(negedge clk);
    chk("add x1 busy", busy_map, 32'h2);
    @(posedge clk); #1;
    wb(1);
    wb(0);
    @(negedge clk);
    chk("x0 wb busy", busy_map, 0);
    // backpressure then flush of x9
    @(posedge clk); #1;
    out_ready = 0;
    issue(32'h00000493, 0, n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold valid", {31'd0, out_valid}, 1);
      chk("hold inst", instOut, 32'h00000493);
    end
    chk("hold busy", busy_map, 32'h200);
    @(posedge clk); #1;
    flush = 1;
    drive(32'h00000093);
    @(negedge clk);
    chk("flush ready", {31'd0, in_ready}, 0);
    void'(q.pop_front());
    @(posedge clk); #1;
    flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("flush valid", {31'd0, out_valid}, 0);
    chk("flush busy", busy_map, 0);
    // inflight limit: a leaked count from the flush would stall x4
    @(posedge clk); #1;
    issue(32'h00000093, 0, n);
    issue(32'h00000113, 0, n);
    issue(32'h00000193, 0, n);
    issue(32'h00000213, 0, n);
    chk("x4 wait", n, 0);
    drive(32'h00000393);
    @(negedge clk);
    chk("limit ready", {31'd0, in_ready}, 0);
    chk("limit busy", busy_map, 32'h1e);
    @(posedge clk); #1;
    exp_stall++;
    issue(32'h00742023, 0, n);
    chk("sw wait", n, 0);
    for (int r = 1; r <= 4; r++) wb(5'(r));
    @(negedge clk);
    chk("limit clear", busy_map, 0);
    // illegal opcode
    @(posedge clk); #1;
    issue(32'h0000007f, 1, n);
    @(negedge clk);
    chk("illegal busy", busy_map, 0);
    @(negedge clk);
    chk("illegal pulse end", {31'd0, illegal_op}, 0);
    // wb and accept of x3 in the same cycle
    @(posedge clk); #1;
    issue(32'h00000193, 0, n);
    drive(32'h00000193);
    wb_valid = 1; wb_rd = 3;
    @(negedge clk);
    chk("collide ready", {31'd0, in_ready}, {31'd0, BYP});
    pushed = in_ready;
    if (pushed) q.push_back('{32'h00000193, 1'b0});
    @(posedge clk); #1;
    wb_valid = 0;
    exp_stall += BYP ? 0 : 1;
    @(negedge clk);
    chk("collide busy", busy_map, BYP ? 32'h8 : 32'h0);
    if (!pushed) begin
      chk("collide late ready", {31'd0, in_ready}, 1);
      q.push_back('{32'h00000193, 1'b0});
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("collide final busy", busy_map, 32'h8);
    @(posedge clk); #1;
    wb(3);
    @(negedge clk);
    chk("x3 clear", busy_map, 0);
    chk("stall count", {16'd0, stall_cnt}, exp_stall);
    // asynchronous reset mid-operation
    @(posedge clk); #1;
    out_ready = 0;
    issue(32'h00500293, 0, n);
    @(negedge clk);
    chk("pre-rst valid", {31'd0, out_valid}, 1);
    chk("pre-rst busy", busy_map, 32'h20);
    q.delete();
    #2 rst_n = 0;
    #1;
    chk("arst valid", {31'd0, out_valid}, 0);
    chk("arst busy", busy_map, 0);
    chk("arst inst", instOut, 0);
    chk("arst stall", {16'd0, stall_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    issue(32'h00000493, 0, n);
    chk("post-rst wait", n, 0);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) chk("queue drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
